// File: rtl/xgmii_tx_arb.sv
// -----------------------------------------------------------------------------
// xgmii_tx_arb
//
// Frame-granular round-robin arbiter for two XGMII frame sources sharing one
// 72-bit transmit word stream (ctrl bits [71:64], data lanes [63:0]).
// Frames are never interleaved. A minimum inter-frame gap is enforced, frames
// are truncated at MAX_WORDS and source underruns are closed with an
// error-terminated word.
//
// Handshake: srcN_valid/srcN_rxd behave like a first-word-fall-through FIFO
// head. srcN_pop is combinational and means "the head word is consumed on the
// next rising edge of xgmii_clk". A pop is only ever raised while srcN_valid
// is high, and never while sys_rst is high.
//
// Ports
//   xgmii_clk            clock
//   sys_rst              asynchronous, active-high reset
//   src0_valid/src1_valid head word present
//   src0_rxd/src1_rxd     head word, XGMII packed
//   src0_pop/src1_pop     head word consumed this cycle (combinational)
//   xgmii_txd            registered transmit word
//   grant                one-hot owner of the frame in progress, 0 when none
//   frm_cnt0/frm_cnt1    frames fully passed per source (wraps)
//   err_cnt              underruns + oversize truncations (wraps)
//   dbg_state            current FSM state (0 IDLE, 1 XMIT, 2 DRAIN, 3 IFG)
// -----------------------------------------------------------------------------
module xgmii_tx_arb #(
    parameter int IFG_WORDS = 1,
    parameter int MAX_WORDS = 192
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst,
    input  logic        src0_valid,
    input  logic [71:0] src0_rxd,
    output logic        src0_pop,
    input  logic        src1_valid,
    input  logic [71:0] src1_rxd,
    output logic        src1_pop,
    output logic [71:0] xgmii_txd,
    output logic [1:0]  grant,
    output logic [15:0] frm_cnt0,
    output logic [15:0] frm_cnt1,
    output logic [15:0] err_cnt,
    output logic [1:0]  dbg_state
);

    localparam logic [71:0] IDLE_W  = 72'hff_0707070707070707;
    localparam logic [71:0] UNDER_W = 72'hff_070707070707fdfe;
    localparam logic [71:0] TRUNC_W = 72'hff_07070707070707fd;
    localparam logic [11:0] WCNT_LAST = 12'(MAX_WORDS - 1);
    localparam logic [3:0]  GCNT_LAST = 4'(IFG_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XMIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_IFG   = 2'd3
    } state_t;

    function automatic logic is_start(input logic [71:0] w);
        return w[64] && (w[7:0] == 8'hfb);
    endfunction

    function automatic logic is_term(input logic [71:0] w);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (w[64+k] && (w[8*k +: 8] == 8'hfd)) r = 1'b1;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] wcnt_q, wcnt_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic        last_q, last_d;
    logic [71:0] txd_d;
    logic [1:0]  pop;
    logic [1:0]  frm_inc;
    logic        err_inc;
    logic [1:0]  cand;
    logic        win;
    logic        own_valid;
    logic [71:0] own_word;

    // During XMIT/DRAIN last_q is the owner of the frame in progress.
    assign own_valid = last_q ? src1_valid : src0_valid;
    assign own_word  = last_q ? src1_rxd   : src0_rxd;
    assign cand      = {src1_valid && is_start(src1_rxd),
                        src0_valid && is_start(src0_rxd)};

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        last_d  = last_q;
        txd_d   = IDLE_W;
        pop     = 2'b00;
        frm_inc = 2'b00;
        err_inc = 1'b0;
        win     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A valid non-START head can never be the winner, so the
                // discard rule is applied to both sources unconditionally.
                if (src0_valid && !is_start(src0_rxd)) pop[0] = 1'b1;
                if (src1_valid && !is_start(src1_rxd)) pop[1] = 1'b1;
                if (cand != 2'b00) begin
                    win      = (cand == 2'b11) ? ~last_q : cand[1];
                    pop[win] = 1'b1;
                    txd_d    = win ? src1_rxd : src0_rxd;
                    wcnt_d   = 12'd1;
                    last_d   = win;
                    state_d  = S_XMIT;
                end
            end
            S_XMIT: begin
                if (own_valid) begin
                    pop[last_q] = 1'b1;
                    if (is_term(own_word)) begin
                        txd_d           = own_word;
                        frm_inc[last_q] = 1'b1;
                        gcnt_d          = 4'd0;
                        state_d         = S_IFG;
                    end else if (wcnt_q == WCNT_LAST) begin
                        txd_d   = TRUNC_W;
                        err_inc = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        txd_d  = own_word;
                        wcnt_d = wcnt_q + 12'd1;
                    end
                end else begin
                    txd_d   = UNDER_W;
                    err_inc = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Throw away the rest of the broken frame up to its Terminate.
                if (own_valid) begin
                    pop[last_q] = 1'b1;
                    if (is_term(own_word)) begin
                        gcnt_d  = 4'd0;
                        state_d = S_IFG;
                    end
                end
            end
            S_IFG: begin
                if (gcnt_q == GCNT_LAST) begin
                    gcnt_d  = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge xgmii_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 12'd0;
            gcnt_q    <= 4'd0;
            last_q    <= 1'b1;
            xgmii_txd <= IDLE_W;
            frm_cnt0  <= 16'd0;
            frm_cnt1  <= 16'd0;
            err_cnt   <= 16'd0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            gcnt_q    <= gcnt_d;
            last_q    <= last_d;
            xgmii_txd <= txd_d;
            if (frm_inc[0]) frm_cnt0 <= frm_cnt0 + 16'd1;
            if (frm_inc[1]) frm_cnt1 <= frm_cnt1 + 16'd1;
            if (err_inc)    err_cnt  <= err_cnt + 16'd1;
        end
    end

    assign src0_pop  = pop[0] && !sys_rst;
    assign src1_pop  = pop[1] && !sys_rst;
    assign grant     = ((state_q == S_XMIT) || (state_q == S_DRAIN))
                       ? (last_q ? 2'b10 : 2'b01) : 2'b00;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_xgmii_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_xgmii_tx_arb
//
// Drives two FWFT frame sources with generated XGMII frames and compares the
// arbiter against a word-level reference model: pops, transmit word, grant
// and counters every cycle.
// -----------------------------------------------------------------------------
module tb_xgmii_tx_arb;

    localparam int IFG_WORDS = 2;
    localparam int MAX_WORDS = 8;
    localparam logic [71:0] IDLE_W  = 72'hff_0707070707070707;
    localparam logic [71:0] UNDER_W = 72'hff_070707070707fdfe;
    localparam logic [71:0] TRUNC_W = 72'hff_07070707070707fd;

    // ---------------- clock / reset ----------------
    logic        xgmii_clk = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        src0_valid = 1'b0;
    logic [71:0] src0_rxd   = '0;
    logic        src0_pop;
    logic        src1_valid = 1'b0;
    logic [71:0] src1_rxd   = '0;
    logic        src1_pop;
    logic [71:0] xgmii_txd;
    logic [1:0]  grant;
    logic [15:0] frm_cnt0, frm_cnt1, err_cnt;
    logic [1:0]  dbg_state;

    always #5 xgmii_clk = ~xgmii_clk;

    xgmii_tx_arb #(.IFG_WORDS(IFG_WORDS), .MAX_WORDS(MAX_WORDS)) dut (
        .xgmii_clk (xgmii_clk),
        .sys_rst   (sys_rst),
        .src0_valid(src0_valid),
        .src0_rxd  (src0_rxd),
        .src0_pop  (src0_pop),
        .src1_valid(src1_valid),
        .src1_rxd  (src1_rxd),
        .src1_pop  (src1_pop),
        .xgmii_txd (xgmii_txd),
        .grant     (grant),
        .frm_cnt0  (frm_cnt0),
        .frm_cnt1  (frm_cnt1),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- sources and scoreboard ----------------
    logic [71:0] sq0[$];
    logic [71:0] sq1[$];
    logic [71:0] fq[$];
    logic [71:0] exp_q[$];
    int          pct0 = 100;
    int          pct1 = 100;
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model: a frame is "open" from its Start until its Terminate
    // is consumed; m_gap counts idle words still owed before arbitration.
    bit          m_open, m_drop, m_owner, m_last;
    int          m_words, m_gap;
    logic [15:0] m_frm0, m_frm1, m_err;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit is_start(input logic [71:0] w);
        return (w[64] == 1'b1) && (w[7:0] == 8'hfb);
    endfunction

    function automatic bit is_term(input logic [71:0] w);
        for (int k = 0; k < 8; k++)
            if (w[64+k] && (w[8*k +: 8] == 8'hfd)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [71:0] data_word();
        return {8'h00, 32'($urandom()), 32'($urandom())};
    endfunction

    // Fills fq with an n-word frame whose Terminate sits in lane tl.
    task automatic build_frame(input int n, input int tl);
        logic [71:0] w;
        fq.delete();
        fq.push_back({8'h01, 32'($urandom()), 24'($urandom()), 8'hfb});
        for (int i = 0; i < n - 2; i++) fq.push_back(data_word());
        w = data_word();
        for (int j = 0; j < 8; j++) begin
            if (j == tl) begin
                w[64+j] = 1'b1; w[8*j +: 8] = 8'hfd;
            end else if (j > tl) begin
                w[64+j] = 1'b1; w[8*j +: 8] = 8'h07;
            end
        end
        fq.push_back(w);
    endtask

    task automatic push_frame(input int src, input int n, input int tl);
        build_frame(n, tl);
        foreach (fq[i]) begin
            if (src == 0) sq0.push_back(fq[i]);
            else          sq1.push_back(fq[i]);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_drop = 0; m_owner = 0; m_last = 1;
        m_words = 0; m_gap = 0;
        m_frm0 = '0; m_frm1 = '0; m_err = '0;
        exp_q.delete();
        exp_q.push_back(IDLE_W);
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Entered just after a falling edge; leaves just after the next one.
    task automatic step();
        logic [71:0] h0, h1, nx, ow;
        bit          v0, v1, e0, e1, c0, c1, w, ov;
        logic [1:0]  g_exp;
        g_exp = m_open ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        check("txd", xgmii_txd, exp_q.pop_front());
        check("grant", 72'(grant), 72'(g_exp));
        check("frm_cnt0", 72'(frm_cnt0), 72'(m_frm0));
        check("frm_cnt1", 72'(frm_cnt1), 72'(m_frm1));
        check("err_cnt", 72'(err_cnt), 72'(m_err));

        v0 = (sq0.size() > 0) && ($urandom_range(99) < 32'(pct0));
        v1 = (sq1.size() > 0) && ($urandom_range(99) < 32'(pct1));
        h0 = (sq0.size() > 0) ? sq0[0] : data_word();
        h1 = (sq1.size() > 0) ? sq1[0] : data_word();
        src0_valid = v0; src0_rxd = h0;
        src1_valid = v1; src1_rxd = h1;
        #1;

        e0 = 0; e1 = 0; nx = IDLE_W;
        if (m_gap > 0) begin
            m_gap--;
        end else if (!m_open) begin
            c0 = v0 && is_start(h0);
            c1 = v1 && is_start(h1);
            if (v0 && !c0) e0 = 1;
            if (v1 && !c1) e1 = 1;
            if (c0 || c1) begin
                w = (c0 && c1) ? !m_last : c1;
                if (w) e1 = 1; else e0 = 1;
                nx = w ? h1 : h0;
                m_open = 1; m_drop = 0; m_owner = w; m_last = w; m_words = 1;
            end
        end else begin
            ov = m_owner ? v1 : v0;
            ow = m_owner ? h1 : h0;
            if (ov) begin
                if (m_owner) e1 = 1; else e0 = 1;
                if (is_term(ow)) begin
                    if (!m_drop) begin
                        nx = ow;
                        if (m_owner) m_frm1++; else m_frm0++;
                    end
                    m_open = 0; m_gap = IFG_WORDS;
                end else if (!m_drop) begin
                    if (m_words == MAX_WORDS - 1) begin
                        nx = TRUNC_W; m_err++; m_drop = 1;
                    end else begin
                        nx = ow; m_words++;
                    end
                end
            end else if (!m_drop) begin
                nx = UNDER_W; m_err++; m_drop = 1;
            end
        end
        check("pop0", 72'(src0_pop), 72'(e0));
        check("pop1", 72'(src1_pop), 72'(e1));
        exp_q.push_back(nx);
        if (e0) void'(sq0.pop_front());
        if (e1) void'(sq1.pop_front());
        @(posedge xgmii_clk);
        @(negedge xgmii_clk);
    endtask

    // Reset is raised in the low phase; its effect must be immediate.
    task automatic reset_dut(input int hold);
        sys_rst = 1'b1;
        #1;
        check("rst_txd", xgmii_txd, IDLE_W);
        check("rst_grant", 72'(grant), 72'(0));
        check("rst_pop0", 72'(src0_pop), 72'(0));
        check("rst_pop1", 72'(src1_pop), 72'(0));
        check("rst_err_cnt", 72'(err_cnt), 72'(0));
        check("rst_frm_cnt0", 72'(frm_cnt0), 72'(0));
        repeat (hold) @(posedge xgmii_clk);
        @(negedge xgmii_clk);
        model_reset();
        sys_rst = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((sq0.size() > 0 || sq1.size() > 0 || m_open || m_gap > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 72'(n < budget), 72'(1));
        repeat (3) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge xgmii_clk);
        reset_dut(2);

        // single 4-word src0 frame, Terminate in lane 3
        push_frame(0, 4, 3);
        run_until_idle(100);
        check("single_frm_cnt0", 72'(frm_cnt0), 72'(1));

        // both sources hold two 3-word frames from reset: alternate 0,1,0,1
        reset_dut(1);
        for (int i = 0; i < 2; i++) begin
            push_frame(0, 3, $urandom_range(7));
            push_frame(1, 3, $urandom_range(7));
        end
        run_until_idle(200);
        check("rr_frm_cnt0", 72'(frm_cnt0), 72'(2));
        check("rr_frm_cnt1", 72'(frm_cnt1), 72'(2));

        // src1 underrun after 2 words, rest of frame arrives later
        build_frame(5, 2);
        sq1.push_back(fq[0]);
        sq1.push_back(fq[1]);
        repeat (6) step();
        for (int i = 2; i < 5; i++) sq1.push_back(fq[i]);
        run_until_idle(100);
        check("under_err_cnt", 72'(err_cnt), 72'(1));

        // 12-word frame against MAX_WORDS = 8
        push_frame(0, 12, 5);
        run_until_idle(100);
        check("trunc_err_cnt", 72'(err_cnt), 72'(2));
        check("trunc_frm_cnt0", 72'(frm_cnt0), 72'(2));

        // stray non-START words while idle are discarded
        for (int i = 0; i < 3; i++) sq0.push_back(data_word());
        run_until_idle(50);

        // reset in the middle of a src1 frame, then a clean frame
        push_frame(1, 7, 0);
        repeat (4) step();
        reset_dut(2);
        push_frame(1, 4, 6);
        run_until_idle(100);
        check("post_rst_frm_cnt1", 72'(frm_cnt1), 72'(1));

        // randomized traffic with valid gaps
        pct0 = 80;
        pct1 = 70;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(5) == 0) sq0.push_back(data_word());
            push_frame($urandom_range(1), $urandom_range(12, 2), $urandom_range(7));
        end
        run_until_idle(5000);

        // randomized traffic without gaps to stress back-to-back frames
        pct0 = 100;
        pct1 = 100;
        for (int i = 0; i < 30; i++)
            push_frame($urandom_range(1), $urandom_range(10, 2), $urandom_range(7));
        run_until_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
